// File: rtl/bist_sequencer.sv
// Exhaustive on-chip verification controller: resets a DUT/reference pair, sweeps every
// stimulus vector once per cycle and compares the two outputs after a fixed pipeline latency.
module bist_sequencer #(
    parameter int IN_W         = 4,
    parameter int OUT_W        = 8,
    parameter int LATENCY      = 1,
    parameter int RESET_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_dut_reset,
    output logic [IN_W-1:0]  o_stim,
    input  logic [OUT_W-1:0] i_dut_out,
    input  logic [OUT_W-1:0] i_ref_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_err_count,
    output logic [IN_W-1:0]  o_first_err_vec,
    output logic             o_first_err_valid
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [IN_W-1:0] LAST_VEC   = {IN_W{1'b1}};
    localparam logic [3:0]      RST_LAST   = 4'(RESET_CYCLES - 1);
    localparam logic [2:0]      DRAIN_LAST = 3'(LATENCY - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      rst_cnt;
    logic [2:0]      drain_cnt;
    logic [IN_W-1:0] stim_nxt;
    logic            dut_reset_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            abort_now;
    logic            cmp_vld;
    logic [IN_W-1:0] cmp_vec;
    logic            mismatch;
    logic [15:0]     err_nxt;

    assign abort_now = i_abort && (state == S_RST || state == S_RUN || state == S_DRAIN);

    // Tag pipeline: the tag leaving it belongs to the DUT output presented this cycle.
    generate
        if (LATENCY == 0) begin : g_direct
            assign cmp_vld = (state == S_RUN);
            assign cmp_vec = o_stim;
        end else begin : g_tag
            logic [LATENCY-1:0] tag_vld_p;
            logic [IN_W-1:0]    tag_vec_p [LATENCY];

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    tag_vld_p <= '0;
                end else if (abort_now) begin
                    tag_vld_p <= '0;
                end else begin
                    tag_vld_p[0] <= (state == S_RUN);
                    for (int i = 1; i < LATENCY; i++) begin
                        tag_vld_p[i] <= tag_vld_p[i-1];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                tag_vec_p[0] <= o_stim;
                for (int i = 1; i < LATENCY; i++) begin
                    tag_vec_p[i] <= tag_vec_p[i-1];
                end
            end

            assign cmp_vld = tag_vld_p[LATENCY-1];
            assign cmp_vec = tag_vec_p[LATENCY-1];
        end
    endgenerate

    // An aborted cycle's comparison is discarded along with the flushed tags.
    assign mismatch = cmp_vld && !abort_now && (i_dut_out != i_ref_out);
    assign err_nxt  = mismatch ? sat_inc(o_err_count) : o_err_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RST;
            S_RST: begin
                if (i_abort)                  state_nxt = S_IDLE;
                else if (rst_cnt == RST_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (i_abort)                 state_nxt = S_IDLE;
                else if (o_stim == LAST_VEC) state_nxt = (LATENCY == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (i_abort)                      state_nxt = S_IDLE;
                else if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        dut_reset_nxt = (state_nxt == S_RST);
        busy_nxt      = (state_nxt == S_RST) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
        done_nxt      = (state_nxt == S_DONE);
        stim_nxt      = (state == S_RUN && state_nxt == S_RUN) ? o_stim + IN_W'(1) : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_dut_reset       <= 1'b1;
            o_stim            <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_pass            <= 1'b0;
            o_err_count       <= 16'd0;
            o_first_err_vec   <= '0;
            o_first_err_valid <= 1'b0;
            rst_cnt           <= 4'd0;
            drain_cnt         <= 3'd0;
        end else begin
            o_dut_reset <= dut_reset_nxt;
            o_stim      <= stim_nxt;
            o_busy      <= busy_nxt;
            o_done      <= done_nxt;
            rst_cnt     <= (state == S_RST) ? rst_cnt + 4'd1 : 4'd0;
            drain_cnt   <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;

            if (state == S_IDLE && state_nxt == S_RST) begin
                o_pass            <= 1'b0;
                o_err_count       <= 16'd0;
                o_first_err_vec   <= '0;
                o_first_err_valid <= 1'b0;
            end else begin
                o_err_count <= err_nxt;
                if (mismatch && !o_first_err_valid) begin
                    o_first_err_vec   <= cmp_vec;
                    o_first_err_valid <= 1'b1;
                end
                // Uses err_nxt so a mismatch in the last drain cycle still fails the run.
                if (state_nxt == S_DONE) o_pass <= (err_nxt == 16'd0);
            end
        end
    end

endmodule
